// File: rtl/clock_enable_ctrl_pkg.sv
// Shared state encoding and helpers for the clock-enable controller.
package clock_enable_ctrl_pkg;

  typedef enum logic [1:0] {
    HALT = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_e;

  // States in which the prescaler advances toward a ce event.
  function automatic logic state_counts(input state_e s);
    return (s == RUN) || (s == STEP);
  endfunction

endpackage

// File: rtl/ce_prescaler.sv
// Prescaler counter: counts 0..div, flags the terminal cycle and wraps to zero.
module ce_prescaler #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 terminal
);

  logic [DIV_WIDTH-1:0] cnt_r;

  // Compared against the live div so a divisor change takes effect at once.
  assign terminal = enable && (cnt_r >= div);

  // Counter update: clear dominates enable; holds when neither is active.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {DIV_WIDTH{1'b0}};
    end else if (clear) begin
      cnt_r <= {DIV_WIDTH{1'b0}};
    end else if (enable) begin
      if (terminal) begin
        cnt_r <= {DIV_WIDTH{1'b0}};
      end else begin
        cnt_r <= cnt_r + DIV_WIDTH'(1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/clock_enable_ctrl.sv
// Clock-enable controller: HALT/RUN/STEP state machine driving a divided ce
// pulse and a running count of issued ce events.
module clock_enable_ctrl
  import clock_enable_ctrl_pkg::*;
#(
  parameter int DIV_WIDTH     = 16,
  parameter int COUNT_WIDTH   = 32,
  parameter bit START_RUNNING = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run_req,
  input  logic                   halt_req,
  input  logic                   step_req,
  input  logic [DIV_WIDTH-1:0]   div,
  output logic                   ce,
  output logic                   running,
  output logic                   step_busy,
  output logic [COUNT_WIDTH-1:0] ce_count
);

  state_e                 state_r;
  logic                   ce_r;
  logic [COUNT_WIDTH-1:0] ce_count_r;
  logic                   clear_s;
  logic                   enable_s;
  logic                   terminal_s;

  // Leaving HALT starts from a zeroed counter because HALT keeps it cleared.
  assign clear_s  = halt_req || (state_r == HALT);
  assign enable_s = state_counts(state_r);

  ce_prescaler #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear_s),
    .enable   (enable_s),
    .div      (div),
    .terminal (terminal_s)
  );

  // State machine with registered ce and event counter; halt_req beats all.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= START_RUNNING ? RUN : HALT;
      ce_r       <= 1'b0;
      ce_count_r <= {COUNT_WIDTH{1'b0}};
    end else if (halt_req) begin
      state_r    <= HALT;
      ce_r       <= 1'b0;
      ce_count_r <= ce_count_r;
    end else begin
      case (state_r)
        HALT: begin
          ce_r       <= 1'b0;
          ce_count_r <= ce_count_r;
          if (step_req) begin
            state_r <= STEP;
          end else if (run_req) begin
            state_r <= RUN;
          end else begin
            state_r <= HALT;
          end
        end
        RUN: begin
          state_r    <= RUN;
          ce_r       <= terminal_s;
          ce_count_r <= terminal_s ? ce_count_r + COUNT_WIDTH'(1) : ce_count_r;
        end
        STEP: begin
          state_r    <= terminal_s ? HALT : STEP;
          ce_r       <= terminal_s;
          ce_count_r <= terminal_s ? ce_count_r + COUNT_WIDTH'(1) : ce_count_r;
        end
        default: begin
          state_r    <= HALT;
          ce_r       <= 1'b0;
          ce_count_r <= ce_count_r;
        end
      endcase
    end
  end

  assign ce        = ce_r;
  assign ce_count  = ce_count_r;
  assign running   = (state_r == RUN);
  assign step_busy = (state_r == STEP);

endmodule

// File: tb/tb_clock_enable_ctrl.sv
// Self-checking bench for clock_enable_ctrl: per-scenario tasks feed an
// expected-output queue each cycle and compare against the DUT after the edge.
module tb_clock_enable_ctrl;

  localparam int DW = 16;
  localparam int CW = 4;

  typedef struct packed {
    logic          ce;
    logic          running;
    logic          step_busy;
    logic [CW-1:0] count;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          run_req;
  logic          halt_req;
  logic          step_req;
  logic [DW-1:0] div;
  logic          ce;
  logic          running;
  logic          step_busy;
  logic [CW-1:0] ce_count;
  logic          ce_b;
  logic          running_b;
  logic          step_busy_b;
  logic [31:0]   ce_count_b;

  obs_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   exp_cnt  = 0;

  // Free-running 10-time-unit clock.
  always #5 clk = ~clk;

  clock_enable_ctrl #(
    .DIV_WIDTH(DW), .COUNT_WIDTH(CW), .START_RUNNING(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .run_req(run_req), .halt_req(halt_req),
    .step_req(step_req), .div(div), .ce(ce), .running(running),
    .step_busy(step_busy), .ce_count(ce_count)
  );

  clock_enable_ctrl #(
    .DIV_WIDTH(DW), .COUNT_WIDTH(32), .START_RUNNING(1'b1)
  ) dut_run (
    .clk(clk), .rst(rst), .run_req(1'b0), .halt_req(1'b0),
    .step_req(1'b0), .div(div), .ce(ce_b), .running(running_b),
    .step_busy(step_busy_b), .ce_count(ce_count_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t observed();
    return obs_t'({ce, running, step_busy, ce_count});
  endfunction

  function automatic obs_t want(input logic c, input logic r, input logic s);
    return obs_t'({c, r, s, CW'(exp_cnt)});
  endfunction

  task automatic test_reset();
    obs_t got, exp;
    int   b_cnt = 0;
    logic b_ce;
    div = 16'd3; run_req = 1'b1; rst = 1'b1;
    exp_cnt = 0;
    exp_q.push_back(want(1'b0, 1'b0, 1'b0));
    tick();
    rst = 1'b0; run_req = 1'b0;
    got = observed(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin
      failures++; $display("FAIL reset_state got=%b want=%b", got, exp);
    end
    checks++;
    if ({ce_b, running_b, step_busy_b, ce_count_b} !== {1'b0, 1'b1, 1'b0, 32'd0}) begin
      failures++; $display("FAIL reset_start_running got=%b%b%b %0d want=010 0", ce_b, running_b, step_busy_b, ce_count_b);
    end
    for (int k = 1; k <= 8; k++) begin
      b_ce = ((k % 4) == 0);
      if (b_ce) b_cnt++;
      exp_q.push_back(want(1'b0, 1'b0, 1'b0));
      tick();
      got = observed(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin
        failures++; $display("FAIL reset_halt_idle k=%0d got=%b want=%b", k, got, exp);
      end
      checks++;
      if ({ce_b, running_b, ce_count_b} !== {b_ce, 1'b1, 32'(b_cnt)}) begin
        failures++; $display("FAIL start_running_ce k=%0d got ce=%b cnt=%0d want ce=%b cnt=%0d", k, ce_b, ce_count_b, b_ce, b_cnt);
      end
    end
  endtask

  task automatic test_step_div0();
    obs_t got, exp;
    logic c;
    div = 16'd0;
    for (int k = 0; k <= 4; k++) begin
      step_req = (k == 0);
      c = (k == 1);
      if (c) exp_cnt++;
      exp_q.push_back(want(c, 1'b0, k == 0));
      tick();
      got = observed(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin
        failures++; $display("FAIL step_div0 k=%0d got=%b want=%b", k, got, exp);
      end
    end
    step_req = 1'b0;
  endtask

  task automatic test_run_div3();
    obs_t got, exp;
    logic c;
    div = 16'd3;
    for (int k = 0; k <= 13; k++) begin
      run_req  = (k == 0);
      halt_req = (k == 13);
      c = (k > 0) && (k < 13) && ((k % 4) == 0);
      if (c) exp_cnt++;
      exp_q.push_back(want(c, k < 13, 1'b0));
      tick();
      got = observed(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin
        failures++; $display("FAIL run_div3 k=%0d got=%b want=%b", k, got, exp);
      end
    end
    run_req = 1'b0; halt_req = 1'b0;
  endtask

  task automatic test_halt_div9();
    obs_t got, exp;
    logic c;
    div = 16'd9;
    for (int k = 0; k <= 30; k++) begin
      run_req  = (k == 0);
      halt_req = (k == 15);
      c = (k == 10);
      if (c) exp_cnt++;
      exp_q.push_back(want(c, k < 15, 1'b0));
      tick();
      got = observed(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin
        failures++; $display("FAIL halt_div9 k=%0d got=%b want=%b", k, got, exp);
      end
    end
    run_req = 1'b0; halt_req = 1'b0;
  endtask

  task automatic test_priority();
    obs_t got, exp;
    logic c;
    div = 16'd2;
    for (int k = 0; k <= 12; k++) begin
      run_req  = (k == 0) || (k == 1) || (k == 7);
      step_req = (k == 4) || (k == 7);
      halt_req = (k == 7);
      c = (k == 3) || (k == 6);
      if (c) exp_cnt++;
      exp_q.push_back(want(c, k < 7, 1'b0));
      tick();
      got = observed(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin
        failures++; $display("FAIL priority k=%0d got=%b want=%b", k, got, exp);
      end
    end
    run_req = 1'b0; step_req = 1'b0; halt_req = 1'b0;
  endtask

  task automatic test_div_change();
    obs_t got, exp;
    logic c;
    for (int k = 0; k <= 19; k++) begin
      div      = (k >= 11) ? 16'd2 : 16'd20;
      run_req  = (k == 0);
      halt_req = (k == 19);
      c = (k == 11) || (k == 14) || (k == 17);
      if (c) exp_cnt++;
      exp_q.push_back(want(c, k < 19, 1'b0));
      tick();
      got = observed(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin
        failures++; $display("FAIL div_change k=%0d got=%b want=%b", k, got, exp);
      end
    end
    run_req = 1'b0; halt_req = 1'b0;
  endtask

  task automatic test_wrap();
    obs_t got, exp;
    logic c;
    div = 16'd0;
    for (int k = 0; k <= 18; k++) begin
      run_req  = (k == 0);
      halt_req = (k == 18);
      c = (k >= 1) && (k <= 17);
      if (c) exp_cnt++;
      exp_q.push_back(want(c, k < 18, 1'b0));
      tick();
      got = observed(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin
        failures++; $display("FAIL count_wrap k=%0d got=%b want=%b", k, got, exp);
      end
    end
    run_req = 1'b0; halt_req = 1'b0;
  endtask

  task automatic test_rst_mid_step();
    obs_t got, exp;
    div = 16'd50;
    for (int k = 0; k <= 70; k++) begin
      step_req = (k == 0);
      rst      = (k == 21);
      if (k == 21) exp_cnt = 0;
      exp_q.push_back(want(1'b0, 1'b0, k < 21));
      tick();
      got = observed(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin
        failures++; $display("FAIL rst_mid_step k=%0d got=%b want=%b", k, got, exp);
      end
    end
    step_req = 1'b0; rst = 1'b0;
  endtask

  // Scenario sequence and summary.
  initial begin
    rst = 1'b1; run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0; div = 16'd3;
    test_reset();
    test_step_div0();
    test_run_div3();
    test_halt_div9();
    test_priority();
    test_div_change();
    test_wrap();
    test_rst_mid_step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
